// File: rtl/midi_voice_ctrl.sv
// Mono MIDI voice controller: byte parser -> note -> NCO phase increment, gate and velocity.
// Latency: inc_valid floor(note/12)+2 cycles after the note-on byte; no backpressure, every wvalid byte is taken.
module midi_voice_ctrl #(
    parameter logic [3:0] CHANNEL   = 4'd0,
    parameter int         CLKFREQ   = 24562500,
    parameter int         ACC_WIDTH = 26
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wvalid,
    input  logic [7:0]           word,
    output logic [ACC_WIDTH-1:0] phase_inc,
    output logic                 inc_valid,
    output logic                 gate,
    output logic [6:0]           note,
    output logic [6:0]           velocity
);

    typedef enum logic [1:0] {P_IDLE, P_WAIT_D1, P_WAIT_D2} pstate_t;
    typedef enum logic [1:0] {C_IDLE, C_DIV, C_APPLY} cstate_t;

    // Top-octave increments (notes 120..131); lower octaves are right shifts of these.
    function automatic logic [ACC_WIDTH-1:0] calc_base(input int k);
        real f;
        real m;
        f = 440.0 * (2.0 ** ((51.0 + k) / 12.0));
        m = f * (2.0 ** ACC_WIDTH) / CLKFREQ;
        return ACC_WIDTH'($rtoi(m + 0.5));
    endfunction

    logic [ACC_WIDTH-1:0] base_tab [12];

    for (genvar k = 0; k < 12; k++) begin : g_base
        localparam logic [ACC_WIDTH-1:0] BASE_K = calc_base(k);
        assign base_tab[k] = BASE_K;
    end

    pstate_t    pstate;
    cstate_t    cstate;
    logic [7:0] rs_dat;
    logic [6:0] d1;
    logic [6:0] div_rem;
    logic [3:0] div_oct;
    logic       gate_pending;

    logic msg_done;
    logic chan_ok;
    logic note_on_evt;
    logic note_off_evt;

    assign msg_done     = wvalid && !word[7] && (pstate == P_WAIT_D2);
    assign chan_ok      = (rs_dat[3:0] == CHANNEL);
    assign note_on_evt  = msg_done && chan_ok && (rs_dat[7:4] == 4'h9) && (word != 8'h00);
    assign note_off_evt = msg_done && chan_ok && (d1 == note) &&
                          ((rs_dat[7:4] == 4'h8) || ((rs_dat[7:4] == 4'h9) && (word == 8'h00)));

    always_ff @(posedge clk) begin
        if (reset) begin
            pstate       <= P_IDLE;
            cstate       <= C_IDLE;
            rs_dat       <= 8'h00;
            d1           <= 7'd0;
            div_rem      <= 7'd0;
            div_oct      <= 4'd0;
            gate_pending <= 1'b0;
            phase_inc    <= '0;
            inc_valid    <= 1'b0;
            gate         <= 1'b0;
            note         <= 7'd0;
            velocity     <= 7'd0;
        end else begin
            inc_valid <= 1'b0;

            // A new note-on restarts the divider, even on what would have been the APPLY edge.
            if (note_on_evt) begin
                div_rem <= d1;
                div_oct <= 4'd0;
                cstate  <= (d1 < 7'd12) ? C_APPLY : C_DIV;
            end else begin
                case (cstate)
                    C_DIV: begin
                        div_rem <= div_rem - 7'd12;
                        div_oct <= div_oct + 4'd1;
                        if (div_rem < 7'd24)
                            cstate <= C_APPLY;
                    end
                    C_APPLY: begin
                        phase_inc <= base_tab[div_rem[3:0]] >> (4'd10 - div_oct);
                        inc_valid <= 1'b1;
                        gate      <= gate_pending;
                        cstate    <= C_IDLE;
                    end
                    default: cstate <= C_IDLE;
                endcase
            end

            if (note_on_evt) begin
                note         <= d1;
                velocity     <= word[6:0];
                gate_pending <= 1'b1;
            end

            // Placed after APPLY so a note-off on the same edge still wins.
            if (note_off_evt) begin
                gate         <= 1'b0;
                gate_pending <= 1'b0;
            end

            if (wvalid && (word < 8'hF8)) begin
                if (word >= 8'hF0) begin
                    pstate <= P_IDLE;
                    rs_dat <= 8'h00;
                end else if (word[7]) begin
                    rs_dat <= word;
                    pstate <= P_WAIT_D1;
                end else begin
                    case (pstate)
                        P_WAIT_D1: begin
                            if (rs_dat[7:5] != 3'b110) begin
                                d1     <= word[6:0];
                                pstate <= P_WAIT_D2;
                            end
                        end
                        P_WAIT_D2: pstate <= P_WAIT_D1;
                        default:   pstate <= P_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_voice_ctrl.sv
// Bench for midi_voice_ctrl: directed scenarios plus a random byte stream against a message-level model.
module tb_midi_voice_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wvalid = 1'b0;
    logic [7:0]  word = 8'h00;
    logic [25:0] phase_inc;
    logic        inc_valid;
    logic        gate;
    logic [6:0]  note;
    logic [6:0]  velocity;

    midi_voice_ctrl #(.CHANNEL(4'd0), .CLKFREQ(24562500), .ACC_WIDTH(26)) dut (
        .clk(clk), .reset(reset), .wvalid(wvalid), .word(word),
        .phase_inc(phase_inc), .inc_valid(inc_valid), .gate(gate),
        .note(note), .velocity(velocity)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_pulse = 0;

    always @(negedge clk) if (inc_valid === 1'b1) n_pulse++;

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // Message-level reference: running status + collected data bytes, timed note calculation.
    int m_status = 0;
    int m_data[$];
    int m_note = 0, m_vel = 0, m_gate = 0, m_pend = 0, m_inc = 0, m_incv = 0, m_cd = -1;

    function automatic int exp_inc(input int n);
        real f;
        real b;
        int  base;
        f = 440.0 * 2.0 ** ((120.0 + (n % 12) - 69.0) / 12.0);
        b = f * (2.0 ** 26) / 24562500.0;
        base = $rtoi(b + 0.5);
        return base >> (10 - n / 12);
    endfunction

    task automatic model_edge();
        bit restarted;
        int len;
        int hi;
        restarted = 0;
        if (reset) begin
            m_status = 0; m_data.delete();
            m_note = 0; m_vel = 0; m_gate = 0; m_pend = 0; m_inc = 0; m_incv = 0; m_cd = -1;
            return;
        end
        m_incv = 0;
        if (wvalid && word < 8'hF8) begin
            if (word >= 8'hF0) begin
                m_status = 0; m_data.delete();
            end else if (word >= 8'h80) begin
                m_status = int'(word); m_data.delete();
            end else if (m_status != 0) begin
                m_data.push_back(int'(word));
                hi = m_status / 16;
                len = (hi == 12 || hi == 13) ? 1 : 2;
                if (m_data.size() == len) begin
                    if (len == 2 && (m_status % 16) == 0) begin
                        if (hi == 9 && m_data[1] != 0) begin
                            m_note = m_data[0]; m_vel = m_data[1]; m_pend = 1;
                            m_cd = m_note / 12 + 1;
                            restarted = 1;
                        end else if ((hi == 8 || hi == 9) && m_data[0] == m_note) begin
                            m_gate = 0; m_pend = 0;
                        end
                    end
                    m_data.delete();
                end
            end
        end
        if (!restarted && m_cd > 0) begin
            m_cd--;
            if (m_cd == 0) begin
                m_inc = exp_inc(m_note); m_incv = 1; m_gate = m_pend; m_cd = -1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        cyc++;
    endtask

    task automatic send(input logic [7:0] b);
        wvalid = 1'b1;
        word = b;
        step();
        wvalid = 1'b0;
        word = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // lat = cycles from the last wvalid cycle to the first inc_valid, -1 if none within maxc.
    task automatic wait_inc(input int maxc, output int lat, output bit g_low);
        lat = -1;
        g_low = 0;
        for (int i = 1; i <= maxc; i++) begin
            step();
            if (gate !== 1'b1) g_low = 1;
            if (inc_valid === 1'b1 && lat < 0) lat = i + 1;
        end
    endtask

    function automatic logic [7:0] rand_byte();
        logic [7:0] ch;
        ch = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 15)) : 8'h00;
        case ($urandom_range(0, 15))
            0, 1:    return 8'h90 | ch;
            2:       return 8'h80 | ch;
            3:       return ($urandom_range(0, 1) == 0) ? 8'hC0 : 8'hD0;
            4:       return 8'hF0 + 8'($urandom_range(0, 7));
            5:       return 8'hF8 + 8'($urandom_range(0, 7));
            6:       return ($urandom_range(0, 1) == 0) ? 8'hA0 : 8'hE0;
            7:       return 8'h00;
            8:       return 8'd69;
            9:       return 8'd60;
            default: return 8'($urandom_range(0, 127));
        endcase
    endfunction

    task automatic test_reset();
        int p0;
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        p0 = n_pulse;
        idle(20);
        checks++; if (phase_inc !== 26'd0) begin failures++; $display("FAIL reset_phase got=%0d exp=0", phase_inc); end
        checks++; if (gate !== 1'b0) begin failures++; $display("FAIL reset_gate got=%b exp=0", gate); end
        checks++; if (note !== 7'd0) begin failures++; $display("FAIL reset_note got=%0d exp=0", note); end
        checks++; if (velocity !== 7'd0) begin failures++; $display("FAIL reset_vel got=%0d exp=0", velocity); end
        checks++; if (n_pulse !== p0) begin failures++; $display("FAIL reset_incv pulses=%0d exp=%0d", n_pulse, p0); end
    endtask

    task automatic test_note_on();
        int p0, lat;
        bit gl;
        send(8'h90); send(8'h45); send(8'h64);
        checks++; if (note !== 7'd69) begin failures++; $display("FAIL on_note got=%0d exp=69", note); end
        checks++; if (velocity !== 7'd100) begin failures++; $display("FAIL on_vel got=%0d exp=100", velocity); end
        p0 = n_pulse;
        wait_inc(14, lat, gl);
        checks++; if (lat !== 7) begin failures++; $display("FAIL on_latency got=%0d exp=7", lat); end
        checks++; if (phase_inc !== 26'd1202) begin failures++; $display("FAIL on_phase got=%0d exp=1202", phase_inc); end
        checks++; if (phase_inc !== 26'(m_inc)) begin failures++; $display("FAIL on_phase_model got=%0d exp=%0d", phase_inc, m_inc); end
        checks++; if (gate !== 1'b1) begin failures++; $display("FAIL on_gate got=%b exp=1", gate); end
        checks++; if (n_pulse - p0 !== 1) begin failures++; $display("FAIL on_pulses got=%0d exp=1", n_pulse - p0); end
    endtask

    task automatic test_running_status();
        int p0, lat;
        bit gl;
        send(8'h3C); send(8'h40);
        wait_inc(14, lat, gl);
        checks++; if (lat !== 7) begin failures++; $display("FAIL rs_latency got=%0d exp=7", lat); end
        checks++; if (phase_inc !== 26'd714) begin failures++; $display("FAIL rs_phase got=%0d exp=714", phase_inc); end
        checks++; if (gl !== 1'b0 || gate !== 1'b1) begin failures++; $display("FAIL rs_legato dropped=%b gate=%b exp gate held 1", gl, gate); end
        send(8'h3C); send(8'h00);
        checks++; if (gate !== 1'b0) begin failures++; $display("FAIL rs_off_gate got=%b exp=0", gate); end
        p0 = n_pulse;
        idle(15);
        checks++; if (phase_inc !== 26'd714) begin failures++; $display("FAIL rs_off_phase got=%0d exp=714", phase_inc); end
        checks++; if (n_pulse !== p0 || gate !== 1'b0) begin failures++; $display("FAIL rs_off_quiet pulses=%0d gate=%b exp=%0d,0", n_pulse, gate, p0); end
    endtask

    task automatic test_filtering();
        int p0, lat;
        bit gl;
        send(8'h90); send(8'h3C); send(8'h40);
        wait_inc(14, lat, gl);
        send(8'h80); send(8'h45); send(8'h00);
        idle(2);
        checks++; if (gate !== 1'b1) begin failures++; $display("FAIL flt_other_off gate=%b exp=1", gate); end
        p0 = n_pulse;
        send(8'h91); send(8'h40); send(8'h40);
        idle(14);
        checks++; if (note !== 7'd60 || velocity !== 7'd64 || n_pulse !== p0) begin
            failures++; $display("FAIL flt_chan note=%0d vel=%0d pulses=%0d exp=60,64,%0d", note, velocity, n_pulse, p0); end
        send(8'h90); send(8'hF8); send(8'h45); send(8'h64);
        checks++; if (note !== 7'd69 || velocity !== 7'd100) begin failures++; $display("FAIL flt_rt note=%0d vel=%0d exp=69,100", note, velocity); end
        wait_inc(14, lat, gl);
        checks++; if (lat !== 7 || phase_inc !== 26'd1202) begin failures++; $display("FAIL flt_rt_inc lat=%0d phase=%0d exp=7,1202", lat, phase_inc); end
        p0 = n_pulse;
        send(8'h90); send(8'hF0); send(8'h45); send(8'h64);
        idle(14);
        checks++; if (n_pulse !== p0 || note !== 7'd69 || phase_inc !== 26'd1202) begin
            failures++; $display("FAIL flt_sysex pulses=%0d note=%0d phase=%0d exp=%0d,69,1202", n_pulse, note, phase_inc, p0); end
    endtask

    task automatic test_boundary();
        int p0, lat;
        bit gl;
        send(8'h90); send(8'h7F); send(8'h01);
        wait_inc(16, lat, gl);
        checks++; if (lat !== 12) begin failures++; $display("FAIL bnd_latency got=%0d exp=12", lat); end
        checks++; if (phase_inc !== 26'd34272) begin failures++; $display("FAIL bnd_phase got=%0d exp=34272", phase_inc); end
        checks++; if (velocity !== 7'd1) begin failures++; $display("FAIL bnd_vel got=%0d exp=1", velocity); end
        p0 = n_pulse;
        send(8'h7F); send(8'h01);
        idle(1);
        send(8'h3C); send(8'h40);
        wait_inc(16, lat, gl);
        checks++; if (n_pulse - p0 !== 1) begin failures++; $display("FAIL abort_pulses got=%0d exp=1", n_pulse - p0); end
        checks++; if (lat !== 7 || phase_inc !== 26'd714 || note !== 7'd60) begin
            failures++; $display("FAIL abort_second lat=%0d phase=%0d note=%0d exp=7,714,60", lat, phase_inc, note); end
    endtask

    task automatic test_reset_mid();
        int p0;
        p0 = n_pulse;
        send(8'h90); send(8'h45); send(8'h64);
        idle(3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle(14);
        checks++; if (n_pulse !== p0) begin failures++; $display("FAIL rmid_pulses got=%0d exp=%0d", n_pulse, p0); end
        checks++; if (phase_inc !== 26'd0 || gate !== 1'b0 || note !== 7'd0 || velocity !== 7'd0) begin
            failures++; $display("FAIL rmid_outputs phase=%0d gate=%b note=%0d vel=%0d exp all 0", phase_inc, gate, note, velocity); end
        send(8'h45); send(8'h64);
        idle(14);
        checks++; if (n_pulse !== p0 || note !== 7'd0 || gate !== 1'b0) begin
            failures++; $display("FAIL rmid_drop pulses=%0d note=%0d gate=%b exp=%0d,0,0", n_pulse, note, gate, p0); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            wvalid = ($urandom_range(0, 2) == 0);
            word = rand_byte();
            reset = ($urandom_range(0, 599) == 0);
            step();
            checks++; if (phase_inc !== 26'(m_inc)) begin failures++; $display("FAIL rand_phase cyc=%0d got=%0d exp=%0d", cyc, phase_inc, m_inc); end
            checks++; if (inc_valid !== 1'(m_incv)) begin failures++; $display("FAIL rand_incv cyc=%0d got=%b exp=%0d", cyc, inc_valid, m_incv); end
            checks++; if (gate !== 1'(m_gate)) begin failures++; $display("FAIL rand_gate cyc=%0d got=%b exp=%0d", cyc, gate, m_gate); end
            checks++; if (note !== 7'(m_note)) begin failures++; $display("FAIL rand_note cyc=%0d got=%0d exp=%0d", cyc, note, m_note); end
            checks++; if (velocity !== 7'(m_vel)) begin failures++; $display("FAIL rand_vel cyc=%0d got=%0d exp=%0d", cyc, velocity, m_vel); end
        end
        wvalid = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_note_on();
        test_running_status();
        test_filtering();
        test_boundary();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/midi_voice_ctrl.md
Name: midi_voice_ctrl

Overview:
- Mono voice controller between the MIDI UART receiver and the NCO/LUT chain.
- Parses the received MIDI byte stream (note on/off, running status, real-time bytes) for one channel.
- Converts the active note number into a phase increment for the 26-bit phase accumulator.
- Drives a gate and velocity for downstream amplitude control.

Parameters:
- CHANNEL, 4'd0, MIDI channel accepted (0 = channel 1).
- CLKFREQ, 24562500, clock frequency in Hz; sets the increment table.
- ACC_WIDTH, 26, phase accumulator width; also the phase_inc width.

Ports:
- clk  in  1  system clock (clk24 domain).
- reset  in  1  synchronous, active-high reset.
- wvalid  in  1  one-cycle strobe: word holds a new received byte.
- word  in  8  received MIDI byte.
- phase_inc  out  ACC_WIDTH  NCO increment (M) for the active note.
- inc_valid  out  1  one-cycle pulse when phase_inc updates.
- gate  out  1  high while a note is held.
- note  out  7  current/pending note number.
- velocity  out  7  note-on velocity of the current note.

Behaviour:
- Reset: all outputs 0, parser IDLE, running status cleared, calculator idle, gate_pending 0.
- Byte classes:
  - Byte >= 0xF8 (real-time) is ignored and leaves parser state untouched.
  - Bytes 0xF0-0xF7 clear running status; parser returns to IDLE.
  - Any other byte >= 0x80 is a status byte: it is latched as running status and the parser goes to WAIT_D1.
  - A data byte (< 0x80) in IDLE with no running status is dropped.
- Parser states: IDLE -> WAIT_D1 -> WAIT_D2 -> (event) -> WAIT_D1 (running status).
  - Status 0xCn/0xDn: one data byte, consumed and ignored, then back to WAIT_D1.
  - Other statuses: two data bytes.
  - A status byte received mid-message discards the partial message.
- Events are decoded only when the status channel equals CHANNEL; all others are consumed silently.
- Note on (0x9n, vel > 0), registered on the edge of the second data byte's wvalid:
  - note <= d1, velocity <= d2, gate_pending <= 1.
  - The calculator starts (or restarts if already busy) with d1.
- Note off (0x8n any velocity, or 0x9n with vel = 0):
  - If d1 == note, then gate <= 0 and gate_pending <= 0 on the same edge.
  - Otherwise no effect.
- Calculator:
  - Registered restoring division by 12, one subtraction per cycle: oct = note/12 (0..10), rem = note%12.
  - Then one APPLY cycle: phase_inc <= BASE[rem] >> (10 - oct), truncating.
  - On APPLY, inc_valid pulses for one cycle and gate <= gate_pending.
  - inc_valid is high exactly floor(note/12)+2 cycles after the triggering wvalid cycle; maximum 12.
  - Legato: if gate is already 1 it stays 1 while the increment changes.
- BASE table (12 x ACC_WIDTH), constants computed at elaboration from CLKFREQ:
  - BASE[k] = round(f(120+k) * 2^ACC_WIDTH / CLKFREQ), where f(n) = 440*2^((n-69)/12).
  - Default BASE[0] = 22874, BASE[7] = 34272, BASE[9] = 38469.
- Simultaneous events:
  - A new note-on during calculation aborts the old calculation; there is no inc_valid for the old note.
  - A matching note-off during calculation lets the calculation finish, but gate stays 0.
- Reset mid-calculation: calculation is aborted, no inc_valid, all outputs return to 0.
- wvalid cannot be stalled; the parser accepts every byte regardless of calculator state.

Test Plan:
- Reset, no stimulus -> phase_inc = 0, gate = 0, note = 0, velocity = 0, inc_valid never high.
- Bytes 0x90,0x45,0x64 -> note = 69, velocity = 100; 7 cycles after the third wvalid: phase_inc = 1202, inc_valid one-cycle pulse, gate = 1.
- Running status, then 0x3C,0x40 -> phase_inc = 714 after 7 cycles, gate stays 1. Then 0x3C,0x00 -> gate = 0 on the next edge, phase_inc holds 714.
- Note 60 held, then 0x80,0x45,0x00 -> gate stays 1. 0x91,0x40,0x40 (channel 2) -> no change. 0x90,0xF8,0x45,0x64 -> parsed as note 69 on. 0x90,0xF0,0x45,0x64 -> ignored (no running status).
- 0x90,0x7F,0x01 -> phase_inc = 34272, inc_valid 12 cycles after the wvalid. Repeat with a second note-on 3 cycles later -> only one inc_valid, for the second note.
- Reset asserted 4 cycles into a note-69 calculation -> no inc_valid, all outputs 0. A following 0x45,0x64 without a status byte -> dropped.
